// File: rtl/cordic_hand_scheduler.sv
// ============================================================================
// Module      : cordic_hand_scheduler
// Description : Shares one CORDIC sin/cos engine between up to four clock-hand
//               requesters. It arbitrates round-robin, drives the CORDIC
//               start/done handshake, scales sin/cos by the hand length
//               (rounding toward zero) and returns X/Y offsets over a
//               valid/ready response channel.
//               Optional build macro: CORDIC_TIMEOUT_EN (bounded wait on done).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_hand_scheduler #(
    parameter int N_REQ   = 3,
    parameter int ANGLE_W = 9,
    parameter int RES_W   = 9,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ANGLE_W-1:0]    req_angle,
    input  logic [N_REQ*LEN_W-1:0]      req_len,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        cordic_start,
    output logic [ANGLE_W-1:0]          cordic_angle,
    input  logic signed [RES_W-1:0]     cordic_sin,
    input  logic signed [RES_W-1:0]     cordic_cos,
    input  logic                        cordic_done,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [1:0]                  rsp_id,
    output logic signed [RES_W-1:0]     rsp_x,
    output logic signed [RES_W-1:0]     rsp_y,
    output logic                        rsp_err
);

    localparam int                 c_P_W       = RES_W + LEN_W + 1;
    localparam logic [1:0]         c_LAST_ID   = 2'(N_REQ - 1);
    localparam logic [ANGLE_W-1:0] c_FULL_TURN = ANGLE_W'(360);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SCALE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_rr;
    logic [1:0]                r_id;
    logic [LEN_W-1:0]          r_len;
    logic [ANGLE_W-1:0]        r_angle;
    logic                      r_start;
    logic signed [RES_W-1:0]   r_sin;
    logic signed [RES_W-1:0]   r_cos;
    logic                      r_valid;
    logic signed [RES_W-1:0]   r_x;
    logic signed [RES_W-1:0]   r_y;

    logic                      w_any;
    logic [1:0]                w_gidx;
    logic [N_REQ-1:0]          w_grant;
    logic [1:0]                w_rr_next;
    logic [ANGLE_W-1:0]        w_ang_sel;
    logic [ANGLE_W-1:0]        w_ang_wrapped;
    logic [LEN_W-1:0]          w_len_sel;
    logic signed [c_P_W-1:0]   w_py;
    logic signed [c_P_W-1:0]   w_px;
    logic [RES_W-1:0]          w_y;
    logic [RES_W-1:0]          w_x;

`ifdef CORDIC_TIMEOUT_EN
    localparam logic [6:0] c_TMO_LAST = 7'(TIMEOUT - 1);
    logic [6:0] r_tmo;
    logic       r_err;
`endif

    // Round-robin search: first asserted requester starting at r_rr, wrapping.
    always_comb begin
        logic [2:0] w_sum;
        w_sum  = '0;
        w_any  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr} + 3'(k);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            if (!w_any && req_valid[w_sum[1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_sum[1:0];
            end
        end
        w_grant = w_any ? (N_REQ'(1) << w_gidx) : '0;
    end

    assign w_rr_next     = (w_gidx == c_LAST_ID) ? 2'd0 : w_gidx + 2'd1;
    assign w_ang_sel     = req_angle[w_gidx*ANGLE_W +: ANGLE_W];
    assign w_len_sel     = req_len[w_gidx*LEN_W +: LEN_W];
    assign w_ang_wrapped = (w_ang_sel >= c_FULL_TURN) ? (w_ang_sel - c_FULL_TURN) : w_ang_sel;

    // Length is unsigned, so it is zero-extended before the signed multiply.
    assign w_py = c_P_W'(r_sin) * $signed(c_P_W'({1'b0, r_len}));
    assign w_px = c_P_W'(r_cos) * $signed(c_P_W'({1'b0, r_len}));

    // Divide by 256 rounding toward zero: shift the magnitude, restore the sign.
    function automatic logic [RES_W-1:0] f_scale(input logic signed [c_P_W-1:0] p);
        logic [c_P_W-1:0] mag;
        logic [c_P_W-1:0] q;
        mag = p[c_P_W-1] ? c_P_W'(-p) : c_P_W'(p);
        q   = mag >> 8;
        q   = p[c_P_W-1] ? (~q + 1'b1) : q;
        return q[RES_W-1:0];
    endfunction

    assign w_y = f_scale(w_py);
    assign w_x = f_scale(w_px);

    // Grant is only offered while idle; reset forces it low immediately.
    assign req_ready    = (r_state == S_IDLE && !reset) ? w_grant : '0;
    assign cordic_start = r_start;
    assign cordic_angle = r_angle;
    assign rsp_valid    = r_valid;
    assign rsp_id       = r_id;
    assign rsp_x        = r_x;
    assign rsp_y        = r_y;
`ifdef CORDIC_TIMEOUT_EN
    assign rsp_err      = r_err;
`else
    assign rsp_err      = 1'b0;
`endif

    // Main sequencer: grant, start pulse, wait for done, scale, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_angle <= '0;
            r_start <= 1'b0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
`ifdef CORDIC_TIMEOUT_EN
            r_tmo   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_start <= 1'b0;
                    if (w_any) begin
                        r_id    <= w_gidx;
                        r_len   <= w_len_sel;
                        r_angle <= w_ang_wrapped;
                        r_rr    <= w_rr_next;
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cordic_done) begin
                        r_sin   <= cordic_sin;
                        r_cos   <= cordic_cos;
                        r_state <= S_SCALE;
`ifdef CORDIC_TIMEOUT_EN
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_tmo   <= r_tmo + 7'd1;
`endif
                    end
                end
                S_SCALE: begin
                    r_x     <= w_x;
                    r_y     <= w_y;
                    r_valid <= 1'b1;
`ifdef CORDIC_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cordic_hand_scheduler.sv
// ============================================================================
// Module      : tb_cordic_hand_scheduler
// Description : Directed bench for cordic_hand_scheduler with a behavioural
//               CORDIC stub (programmable sin/cos, start->done latency 12).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_hand_scheduler;

    logic                clk = 1'b0;
    logic                reset;
    logic [2:0]          req_valid;
    logic [26:0]         req_angle;
    logic [23:0]         req_len;
    logic [2:0]          req_ready;
    logic                cordic_start;
    logic [8:0]          cordic_angle;
    logic signed [8:0]   cordic_sin;
    logic signed [8:0]   cordic_cos;
    logic                cordic_done;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic signed [8:0]   rsp_x;
    logic signed [8:0]   rsp_y;
    logic                rsp_err;

    logic signed [8:0]   stub_sin;
    logic signed [8:0]   stub_cos;
    logic                stub_mute;
    int                  stub_cnt = 0;
    int                  starts   = 0;

    int                  total = 0;
    int                  bad   = 0;

    cordic_hand_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_angle    (req_angle),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .cordic_start (cordic_start),
        .cordic_angle (cordic_angle),
        .cordic_sin   (cordic_sin),
        .cordic_cos   (cordic_cos),
        .cordic_done  (cordic_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_x        (rsp_x),
        .rsp_y        (rsp_y),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // CORDIC stub: done pulses 12 cycles after the cycle start was high.
    always @(posedge clk) begin
        if (cordic_start) begin
            stub_cnt <= 12;
            starts   <= starts + 1;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign cordic_done = (stub_cnt == 1) && !stub_mute;
    assign cordic_sin  = stub_sin;
    assign cordic_cos  = stub_cos;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [8:0] ang, input logic [7:0] len);
        req_angle[i*9 +: 9] = ang;
        req_len[i*8 +: 8]   = len;
    endtask

    task automatic wait_grant(output int g);
        int n;
        #1;
        n = 0;
        while (req_ready == 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", 32'(req_ready != 3'b000), 1);
        g = 0;
        for (int i = 0; i < 3; i++) if (req_ready[i]) g = i;
    endtask

    task automatic wait_rsp(input int lim);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", 32'(rsp_valid), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready),    0);
        check({tag, "_start"}, 32'(cordic_start), 0);
        check({tag, "_angle"}, 32'(cordic_angle), 0);
        check({tag, "_valid"}, 32'(rsp_valid),    0);
        check({tag, "_id"},    32'(rsp_id),       0);
        check({tag, "_x"},     32'(rsp_x),        0);
        check({tag, "_y"},     32'(rsp_y),        0);
        check({tag, "_err"},   32'(rsp_err),      0);
    endtask

    initial begin
        int g;
        int s0;
        logic [8:0] ang_in  [3];
        logic [8:0] ang_exp [3];
        ang_in[0]  = 9'd511; ang_in[1]  = 9'd359; ang_in[2]  = 9'd360;
        ang_exp[0] = 9'd151; ang_exp[1] = 9'd359; ang_exp[2] = 9'd0;

        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;
        req_len   = '0;
        rsp_ready = 1'b0;
        stub_sin  = '0;
        stub_cos  = '0;
        stub_mute = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Test 1: req0 angle 90 len 128, sin 255 cos 0, exact latency 15.
        set_req(0, 9'd90, 8'd128);
        stub_sin  = 9'sd255;
        stub_cos  = 9'sd0;
        rsp_ready = 1'b1;
        req_valid = 3'b001;
        s0 = starts;
        #1;
        check("t1_grant", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 3'b000;
        check("t1_start", 32'(cordic_start), 1);
        check("t1_angle", 32'(cordic_angle), 90);
        @(negedge clk);
        check("t1_start_low", 32'(cordic_start), 0);
        repeat (12) @(negedge clk);
        check("t1_valid_c14", 32'(rsp_valid), 0);
        @(negedge clk);
        check("t1_valid_c15", 32'(rsp_valid), 1);
        check("t1_id", 32'(rsp_id), 0);
        check("t1_x", rsp_x, 0);
        check("t1_y", rsp_y, 127);
        check("t1_starts", starts - s0, 1);
        @(negedge clk);
        check("t1_valid_done", 32'(rsp_valid), 0);

        // Test 2: req1 angle 400 len 100, sin -255 cos -128.
        set_req(1, 9'd400, 8'd100);
        stub_sin  = -9'sd255;
        stub_cos  = -9'sd128;
        req_valid = 3'b010;
        #1;
        check("t2_grant", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 3'b000;
        check("t2_angle", 32'(cordic_angle), 40);
        wait_rsp(30);
        check("t2_id", 32'(rsp_id), 1);
        check("t2_x", rsp_x, -50);
        check("t2_y", rsp_y, -99);
        @(negedge clk);

        // Test 3: after reset, all requesters held -> order 0,1,2,0,1.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_req(i, ang_in[i], 8'd10);
        stub_sin  = 9'sd100;
        stub_cos  = -9'sd100;
        s0 = starts;
        req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            check("t3_order", g, k % 3);
            @(negedge clk);
            check("t3_wrap", 32'(cordic_angle), 32'(ang_exp[k % 3]));
            wait_rsp(30);
            if (k == 4) req_valid = 3'b000;
        end
        @(negedge clk);
        check("t3_starts", starts - s0, 5);

        // Test 4: backpressure in RESP holds outputs and blocks new grants.
        set_req(2, 9'd0, 8'd200);
        set_req(0, 9'd30, 8'd50);
        stub_sin  = -9'sd1;
        stub_cos  = 9'sd255;
        rsp_ready = 1'b0;
        req_valid = 3'b100;
        wait_grant(g);
        check("t4_grant", g, 2);
        @(negedge clk);
        req_valid = 3'b001;
        check("t4_busy_ready", 32'(req_ready), 0);
        wait_rsp(30);
        check("t4_id", 32'(rsp_id), 2);
        check("t4_x", rsp_x, 199);
        check("t4_y", rsp_y, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid), 1);
            check("t4_hold_x", rsp_x, 199);
            check("t4_hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_released", 32'(rsp_valid), 0);
        check("t4_next_grant", 32'(req_ready), 1);
        stub_sin = 9'sd200;
        stub_cos = -9'sd200;
        @(negedge clk);
        req_valid = 3'b000;
        wait_rsp(30);
        check("t4b_id", 32'(rsp_id), 0);
        check("t4b_x", rsp_x, -39);
        check("t4b_y", rsp_y, 39);
        @(negedge clk);

        // Test 5: reset mid-WAIT clears outputs; a stale done is ignored.
        set_req(1, 9'd300, 8'd255);
        stub_sin  = 9'sd255;
        stub_cos  = 9'sd255;
        req_valid = 3'b010;
        #1;
        check("t5_grant", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 3'b000;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outputs("t5_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        s0 = starts;
        repeat (15) @(negedge clk);
        check("t5_no_rsp", 32'(rsp_valid), 0);
        check("t5_no_start", starts - s0, 0);
        stub_sin  = -9'sd128;
        stub_cos  = 9'sd64;
        req_valid = 3'b110;
        #1;
        check("t5_rr_reset", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 3'b000;
        check("t5_angle", 32'(cordic_angle), 300);
        wait_rsp(30);
        check("t5_id", 32'(rsp_id), 1);
        check("t5_x", rsp_x, 63);
        check("t5_y", rsp_y, -127);
        @(negedge clk);

`ifdef CORDIC_TIMEOUT_EN
        // Test 6: done never arrives -> error response after 64 WAIT cycles.
        stub_mute = 1'b1;
        set_req(2, 9'd45, 8'd100);
        req_valid = 3'b100;
        #1;
        check("t6_grant", 32'(req_ready), 4);
        @(negedge clk);
        req_valid = 3'b000;
        repeat (64) @(negedge clk);
        check("t6_valid_early", 32'(rsp_valid), 0);
        @(negedge clk);
        check("t6_valid", 32'(rsp_valid), 1);
        check("t6_err", 32'(rsp_err), 1);
        check("t6_x", rsp_x, 0);
        check("t6_y", rsp_y, 0);
        @(negedge clk);
        stub_mute = 1'b0;
        set_req(0, 9'd90, 8'd128);
        stub_sin  = 9'sd255;
        stub_cos  = 9'sd0;
        req_valid = 3'b001;
        wait_grant(g);
        check("t6b_grant", g, 0);
        @(negedge clk);
        req_valid = 3'b000;
        wait_rsp(30);
        check("t6b_err", 32'(rsp_err), 0);
        check("t6b_y", rsp_y, 127);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
